bist_engine: RTL and testbench



---
 rtl/bist_pkg.sv | 13 +
 rtl/bist_engine_if.sv | 18 +
 rtl/bist_lfsr.sv | 18 +
 rtl/bist_misr.sv | 20 ++
 rtl/bist_engine.sv | 66 ++++++
 tb/tb_bist_engine.sv | 161 ++++++++++++++++
 6 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared FSM state type, sizing helper and default polynomials for the BIST engine
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [4:0] LFSR_TAPS_5 = 5'b10100;
  localparam logic [3:0] MISR_POLY_4 = 4'b0011;
  localparam logic [7:0] MISR_POLY_8 = 8'h1d;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/bist_engine_if.sv
// bist_engine_if: control, golden compare and CUT pattern/response bundle of the BIST engine
interface bist_engine_if #(
  parameter int PAT_W = 5,
  parameter int SIG_W = 4,
  parameter int RESP_W = 1
);
  logic start;
  logic abort;
  logic [SIG_W-1:0] golden;
  logic [RESP_W-1:0] resp;
  logic [PAT_W-1:0] pat;
  logic [SIG_W-1:0] sig;
  logic busy;
  logic done;
  logic pass;
  modport master(output start, abort, golden, resp, input pat, sig, busy, done, pass);
  modport slave(input start, abort, golden, resp, output pat, sig, busy, done, pass);
endinterface

// File: rtl/bist_lfsr.sv
// bist_lfsr: Fibonacci LFSR shifting left, feedback is the XOR of the masked state bits
module bist_lfsr #(
  parameter int W = 5,
  parameter logic [W-1:0] TAPS = 5'b10100
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic [W-1:0] seed,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (load) q <= seed;
    else if (en) q <= {q[W-2:0], ^(q & TAPS)};
  end
endmodule

// File: rtl/bist_misr.sv
// bist_misr: Galois MISR; nxt exposes the next signature so a compare can use it in the same cycle
module bist_misr #(
  parameter int W = 4,
  parameter logic [W-1:0] POLY = 4'b0011,
  parameter int IN_W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic [IN_W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);
  assign nxt = {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ W'(d);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en) q <= nxt;
  end
endmodule

// File: rtl/bist_engine.sv
// bist_engine: LFSR pattern source, MISR compactor and IDLE/RUN/DONE control with golden compare
module bist_engine
  import bist_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter logic [PAT_W-1:0] PAT_TAPS = LFSR_TAPS_5,
  parameter logic [PAT_W-1:0] SEED = 5'b00001,
  parameter int N_PAT = 31,
  parameter int SIG_W = 4,
  parameter logic [SIG_W-1:0] SIG_POLY = MISR_POLY_4,
  parameter int RESP_W = 1
) (
  input logic clk,
  input logic rst,
  bist_engine_if.slave bus
);
  localparam int CNT_W = clog2(N_PAT + 1);
  localparam logic [PAT_W-1:0] SEED_EFF = (SEED == '0) ? PAT_W'(1) : SEED;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [PAT_W-1:0] pat;
  logic [SIG_W-1:0] sig, sig_nxt;
  logic busy, done, pass;
  logic launch, step;
  assign launch = (state != RUN) && bus.start;
  assign step = (state == RUN) && !bus.abort;
  bist_lfsr #(.W(PAT_W), .TAPS(PAT_TAPS)) u_lfsr (
    .clk(clk), .rst(rst), .load(launch), .en(step), .seed(SEED_EFF), .q(pat)
  );
  bist_misr #(.W(SIG_W), .POLY(SIG_POLY), .IN_W(RESP_W)) u_misr (
    .clk(clk), .rst(rst), .clr(launch), .en(step), .d(bus.resp), .q(sig), .nxt(sig_nxt)
  );
  assign bus.pat = pat;
  assign bus.sig = sig;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.pass = pass;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (launch) begin
      state <= RUN;
      cnt <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state == RUN && bus.abort) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(N_PAT - 1)) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (sig_nxt == bus.golden);
      end
    end
  end
endmodule

// File: tb/tb_bist_engine.sv
// tb_bist_engine: directed checks of the default 5-bit/4-bit engine and an 8-bit parameter sweep
module tb_bist_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int nb, distinct;
  logic [4:0] pats [31];
  logic seen [256];
  bist_engine_if b ();
  bist_engine_if #(.PAT_W(8), .SIG_W(8), .RESP_W(4)) w ();
  bist_engine u_def (.clk(clk), .rst(rst), .bus(b));
  bist_engine #(
    .PAT_W(8), .PAT_TAPS(8'b10111000), .SEED(8'd1), .N_PAT(255),
    .SIG_W(8), .SIG_POLY(8'h1d), .RESP_W(4)
  ) u_swp (.clk(clk), .rst(rst), .bus(w));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic [4:0] p, input logic [3:0] s,
                      input logic bz, input logic dn, input logic ps);
    check({tag, ".pat"}, 32'(b.pat), 32'(p));
    check({tag, ".sig"}, 32'(b.sig), 32'(s));
    check({tag, ".busy"}, 32'(b.busy), 32'(bz));
    check({tag, ".done"}, 32'(b.done), 32'(dn));
    check({tag, ".pass"}, 32'(b.pass), 32'(ps));
  endtask
  task automatic run5(input logic r0, input logic hold);
    b.start = 1'b1;
    tick;
    b.start = hold;
    nb = 0;
    distinct = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 31; i++) begin
      b.resp = (i == 0) ? r0 : 1'b0;
      pats[i] = b.pat;
      nb += int'(b.busy);
      if (b.pat != 0 && !seen[int'(b.pat)]) distinct++;
      seen[int'(b.pat)] = 1'b1;
      tick;
    end
    b.resp = 1'b0;
  endtask
  initial begin
    b.start = 0; b.abort = 0; b.golden = 0; b.resp = 0;
    w.start = 0; w.abort = 0; w.golden = 0; w.resp = 0;
    tick;
    tick;
    outs("reset", 5'h00, 4'h0, 0, 0, 0);
    rst = 1'b0;
    // zero response, zero golden
    run5(1'b0, 1'b0);
    check("seq0", 32'(pats[0]), 32'h01);
    check("seq1", 32'(pats[1]), 32'h02);
    check("seq2", 32'(pats[2]), 32'h04);
    check("seq3", 32'(pats[3]), 32'h09);
    check("seq4", 32'(pats[4]), 32'h12);
    check("seq5", 32'(pats[5]), 32'h05);
    check("distinct31", 32'(distinct), 32'd31);
    check("busy31", 32'(nb), 32'd31);
    outs("zero_run", 5'h01, 4'h0, 0, 1, 1);
    repeat (3) tick;
    outs("done_hold", 5'h01, 4'h0, 0, 1, 1);
    b.abort = 1'b1;
    tick;
    b.abort = 1'b0;
    outs("abort_in_done", 5'h01, 4'h0, 0, 1, 1);
    // single response bit: x^30 mod x^4+x+1 = 1
    b.golden = 4'h1;
    run5(1'b1, 1'b0);
    outs("one_hit_pass", 5'h01, 4'h1, 0, 1, 1);
    b.golden = 4'h2;
    run5(1'b1, 1'b0);
    outs("one_hit_fail", 5'h01, 4'h1, 0, 1, 0);
    // abort in RUN cycle 10
    b.start = 1'b1;
    b.resp = 1'b1;
    tick;
    b.start = 1'b0;
    b.resp = 1'b0;
    repeat (9) tick;
    check("pre_abort.pat", 32'(b.pat), 32'h19);
    check("pre_abort.busy", 32'(b.busy), 32'd1);
    b.abort = 1'b1;
    b.start = 1'b1;
    tick;
    b.abort = 1'b0;
    b.start = 1'b0;
    check("abort.pat", 32'(b.pat), 32'h19);
    check("abort.busy", 32'(b.busy), 32'd0);
    check("abort.done", 32'(b.done), 32'd0);
    check("abort.pass", 32'(b.pass), 32'd0);
    repeat (2) tick;
    check("abort_idle.busy", 32'(b.busy), 32'd0);
    b.golden = 4'h1;
    run5(1'b1, 1'b0);
    check("after_abort.busy31", 32'(nb), 32'd31);
    outs("after_abort", 5'h01, 4'h1, 0, 1, 1);
    // reset together with start, mid-run
    b.start = 1'b1;
    tick;
    b.start = 1'b0;
    b.resp = 1'b1;
    tick;
    b.resp = 1'b0;
    repeat (4) tick;
    check("mid.sig", 32'(b.sig), 32'h3);
    check("mid.pat", 32'(b.pat), 32'h05);
    rst = 1'b1;
    b.start = 1'b1;
    b.abort = 1'b1;
    tick;
    rst = 1'b0;
    b.start = 1'b0;
    b.abort = 1'b0;
    outs("rst_mid", 5'h00, 4'h0, 0, 0, 0);
    tick;
    outs("rst_idle", 5'h00, 4'h0, 0, 0, 0);
    // start held through RUN and into DONE
    b.golden = 4'h1;
    run5(1'b1, 1'b1);
    check("held.busy31", 32'(nb), 32'd31);
    outs("held_done", 5'h01, 4'h1, 0, 1, 1);
    tick;
    b.start = 1'b0;
    outs("held_restart", 5'h01, 4'h0, 1, 0, 0);
    repeat (31) tick;
    outs("held_second", 5'h01, 4'h0, 0, 1, 0);
    // 8-bit sweep: maximal-length period 255
    w.start = 1'b1;
    tick;
    w.start = 1'b0;
    nb = 0;
    distinct = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      nb += int'(w.busy);
      if (w.pat != 0 && !seen[int'(w.pat)]) distinct++;
      seen[int'(w.pat)] = 1'b1;
      tick;
    end
    check("swp.distinct255", 32'(distinct), 32'd255);
    check("swp.busy255", 32'(nb), 32'd255);
    check("swp.pat", 32'(w.pat), 32'h01);
    check("swp.sig", 32'(w.sig), 32'h00);
    check("swp.done", 32'(w.done), 32'd1);
    check("swp.pass", 32'(w.pass), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
